// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer
//
// Keypad number-entry register. Builds a multi-digit value one digit per strobe
// in a configurable radix. Supports backspace, clear, overflow rejection and a
// valid/ready commit port, so a committed operand can wait downstream while the
// next number is typed.
//
// Parameters:
//   WIDTH      - bit width of the entry value and the committed result
//   RADIX      - digit base, 2..16
//   MAX_DIGITS - maximum digits per entry, 1..8
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   keyboard_digit in   digit code, sampled with digit_enable
//   digit_enable   in   strobe: append keyboard_digit
//   backspace      in   strobe: drop the last digit
//   clear          in   strobe: empty the entry
//   enter          in   strobe: commit the entry to the result port
//   value          out  current entry value
//   digit_count    out  digits currently held
//   reject         out  one-cycle pulse: previous cycle's request refused
//   result         out  committed value, stable while result_valid
//   result_valid   out  committed value pending
//   result_ready   in   downstream accepts result when high with result_valid
module digit_entry_buffer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned RADIX      = 10,
    parameter int unsigned MAX_DIGITS = 4,
    localparam int unsigned CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       keyboard_digit,
    input  logic             digit_enable,
    input  logic             backspace,
    input  logic             clear,
    input  logic             enter,
    output logic [WIDTH-1:0] value,
    output logic [CW-1:0]    digit_count,
    output logic             reject,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int unsigned IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    // value*RADIX + digit never exceeds WIDTH+5 bits for RADIX <= 16.
    localparam int unsigned EW = WIDTH + 5;

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]    count_q, count_d;
    logic             reject_q, reject_d;
    logic [WIDTH-1:0] result_q, result_d;

    // History of pre-push values; backspace restores instead of dividing.
    logic [WIDTH-1:0] stack_q [MAX_DIGITS];
    logic             push;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    pop_idx;

    logic [EW-1:0]    ext_value;
    logic             digit_ok;

    assign push_idx  = IW'(count_q);
    assign pop_idx   = IW'(count_q - CW'(1));
    assign ext_value = EW'(value_q) * EW'(RADIX) + EW'(keyboard_digit);
    assign digit_ok  = (32'(keyboard_digit) < RADIX) &&
                       (32'(count_q) < MAX_DIGITS) &&
                       (ext_value <= EW'({WIDTH{1'b1}}));

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        count_d  = count_q;
        reject_d = 1'b0;
        result_d = result_q;
        push     = 1'b0;

        // Transfer happens regardless of any entry command this cycle.
        if (state_q == StFull && result_ready) begin
            state_d = StEmpty;
        end

        // Priority: clear > enter > backspace > digit; lower strobes dropped.
        if (clear) begin
            value_d = '0;
            count_d = '0;
        end else if (enter) begin
            // A commit is judged on the state before this edge, so enter in the
            // transfer cycle is still refused.
            if (state_q == StEmpty && count_q != '0) begin
                result_d = value_q;
                value_d  = '0;
                count_d  = '0;
                state_d  = StFull;
            end else begin
                reject_d = 1'b1;
            end
        end else if (backspace) begin
            if (count_q != '0) begin
                value_d = stack_q[pop_idx];
                count_d = count_q - CW'(1);
            end else begin
                reject_d = 1'b1;
            end
        end else if (digit_enable) begin
            if (digit_ok) begin
                value_d = ext_value[WIDTH-1:0];
                count_d = count_q + CW'(1);
                push    = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StEmpty;
            value_q  <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            count_q  <= count_d;
            reject_q <= reject_d;
            result_q <= result_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clock) begin
        if (push) begin
            stack_q[push_idx] <= value_q;
        end
    end

    assign value        = value_q;
    assign digit_count  = count_q;
    assign reject       = reject_q;
    assign result       = result_q;
    assign result_valid = (state_q == StFull);

endmodule

// File: tb/tb_digit_entry_buffer.sv
module tb_digit_entry_buffer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keyboard_digit = 4'd0;
    logic       digit_enable = 1'b0;
    logic       backspace = 1'b0;
    logic       clear = 1'b0;
    logic       enter = 1'b0;
    logic       result_ready = 1'b0;

    // Default instance: WIDTH=16, RADIX=10, MAX_DIGITS=4
    logic [15:0] val_d, res_d;
    logic [2:0]  cnt_d;
    logic        rej_d, rv_d;
    // WIDTH=8, MAX_DIGITS=3
    logic [7:0]  val_w8, res_w8;
    logic [1:0]  cnt_w8;
    logic        rej_w8, rv_w8;
    // RADIX=16
    logic [15:0] val_h, res_h;
    logic [2:0]  cnt_h;
    logic        rej_h, rv_h;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    digit_entry_buffer u_dut (
        .clock(clock), .reset(reset), .keyboard_digit(keyboard_digit),
        .digit_enable(digit_enable), .backspace(backspace), .clear(clear), .enter(enter),
        .value(val_d), .digit_count(cnt_d), .reject(rej_d), .result(res_d),
        .result_valid(rv_d), .result_ready(result_ready)
    );

    digit_entry_buffer #(.WIDTH(8), .RADIX(10), .MAX_DIGITS(3)) u_w8 (
        .clock(clock), .reset(reset), .keyboard_digit(keyboard_digit),
        .digit_enable(digit_enable), .backspace(backspace), .clear(clear), .enter(enter),
        .value(val_w8), .digit_count(cnt_w8), .reject(rej_w8), .result(res_w8),
        .result_valid(rv_w8), .result_ready(result_ready)
    );

    digit_entry_buffer #(.WIDTH(16), .RADIX(16), .MAX_DIGITS(4)) u_hex (
        .clock(clock), .reset(reset), .keyboard_digit(keyboard_digit),
        .digit_enable(digit_enable), .backspace(backspace), .clear(clear), .enter(enter),
        .value(val_h), .digit_count(cnt_h), .reject(rej_h), .result(res_h),
        .result_valid(rv_h), .result_ready(result_ready)
    );

    // Drive one cycle of strobes, let one edge sample them, return #1 after it.
    task automatic apply(input logic [3:0] d, input logic de, input logic bs,
                         input logic clr, input logic ent, input logic rdy);
        keyboard_digit = d;
        digit_enable   = de;
        backspace      = bs;
        clear          = clr;
        enter          = ent;
        result_ready   = rdy;
        @(posedge clock);
        #1;
        digit_enable   = 1'b0;
        backspace      = 1'b0;
        clear          = 1'b0;
        enter          = 1'b0;
        result_ready   = 1'b0;
    endtask

    task automatic digit(input logic [3:0] d);
        apply(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (val_d !== 16'd0) begin n_fail++; $display("FAIL reset_value: got %0d expected 0", val_d); end
        n_checks++; if (cnt_d !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt_d); end
        n_checks++; if (rej_d !== 1'b0) begin n_fail++; $display("FAIL reset_reject: got %0d expected 0", rej_d); end
        n_checks++; if (res_d !== 16'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", res_d); end
        n_checks++; if (rv_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", rv_d); end
        reset = 1'b0;
    endtask

    task automatic test_basic_entry;
        digit(4'd4);
        n_checks++; if (val_d !== 16'd4) begin n_fail++; $display("FAIL basic_value4: got %0d expected 4", val_d); end
        n_checks++; if (cnt_d !== 3'd1) begin n_fail++; $display("FAIL basic_count1: got %0d expected 1", cnt_d); end
        digit(4'd6);
        n_checks++; if (val_d !== 16'd46) begin n_fail++; $display("FAIL basic_value46: got %0d expected 46", val_d); end
        n_checks++; if (rej_d !== 1'b0) begin n_fail++; $display("FAIL basic_noreject: got %0d expected 0", rej_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (res_d !== 16'd46) begin n_fail++; $display("FAIL commit_result: got %0d expected 46", res_d); end
        n_checks++; if (rv_d !== 1'b1) begin n_fail++; $display("FAIL commit_valid: got %0d expected 1", rv_d); end
        n_checks++; if (val_d !== 16'd0) begin n_fail++; $display("FAIL commit_value_cleared: got %0d expected 0", val_d); end
        n_checks++; if (cnt_d !== 3'd0) begin n_fail++; $display("FAIL commit_count_cleared: got %0d expected 0", cnt_d); end
    endtask

    task automatic test_pending_entry;
        digit(4'd1);
        digit(4'd2);
        n_checks++; if (val_d !== 16'd12) begin n_fail++; $display("FAIL pending_value12: got %0d expected 12", val_d); end
        n_checks++; if (res_d !== 16'd46) begin n_fail++; $display("FAIL pending_result_held: got %0d expected 46", res_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rej_d !== 1'b1) begin n_fail++; $display("FAIL full_enter_reject: got %0d expected 1", rej_d); end
        n_checks++; if (val_d !== 16'd12) begin n_fail++; $display("FAIL full_enter_value: got %0d expected 12", val_d); end
        n_checks++; if (res_d !== 16'd46) begin n_fail++; $display("FAIL full_enter_result: got %0d expected 46", res_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rv_d !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %0d expected 0", rv_d); end
        n_checks++; if (rej_d !== 1'b0) begin n_fail++; $display("FAIL reject_one_cycle: got %0d expected 0", rej_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (res_d !== 16'd12) begin n_fail++; $display("FAIL second_commit_result: got %0d expected 12", res_d); end
        n_checks++; if (rv_d !== 1'b1) begin n_fail++; $display("FAIL second_commit_valid: got %0d expected 1", rv_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (rv_d !== 1'b0) begin n_fail++; $display("FAIL second_drain_valid: got %0d expected 0", rv_d); end
    endtask

    task automatic test_digit_limit;
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        digit(4'd3);
        digit(4'd2);
        digit(4'd7);
        digit(4'd5);
        n_checks++; if (val_d !== 16'd3275) begin n_fail++; $display("FAIL limit_value: got %0d expected 3275", val_d); end
        n_checks++; if (cnt_d !== 3'd4) begin n_fail++; $display("FAIL limit_count: got %0d expected 4", cnt_d); end
        digit(4'd8);
        n_checks++; if (rej_d !== 1'b1) begin n_fail++; $display("FAIL limit_reject: got %0d expected 1", rej_d); end
        n_checks++; if (val_d !== 16'd3275) begin n_fail++; $display("FAIL limit_value_kept: got %0d expected 3275", val_d); end
        n_checks++; if (cnt_d !== 3'd4) begin n_fail++; $display("FAIL limit_count_kept: got %0d expected 4", cnt_d); end
        apply(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (rej_d !== 1'b0) begin n_fail++; $display("FAIL limit_reject_once: got %0d expected 0", rej_d); end
        n_checks++; if (val_d !== 16'd327) begin n_fail++; $display("FAIL bs_value327: got %0d expected 327", val_d); end
        apply(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (val_d !== 16'd32) begin n_fail++; $display("FAIL bs_value32: got %0d expected 32", val_d); end
        n_checks++; if (cnt_d !== 3'd2) begin n_fail++; $display("FAIL bs_count2: got %0d expected 2", cnt_d); end
        apply(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (val_d !== 16'd3) begin n_fail++; $display("FAIL bs_value3: got %0d expected 3", val_d); end
        n_checks++; if (cnt_d !== 3'd1) begin n_fail++; $display("FAIL bs_count1: got %0d expected 1", cnt_d); end
    endtask

    task automatic test_overflow;
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        digit(4'd2);
        digit(4'd5);
        n_checks++; if (val_w8 !== 8'd25) begin n_fail++; $display("FAIL w8_value25: got %0d expected 25", val_w8); end
        digit(4'd6);
        n_checks++; if (rej_w8 !== 1'b1) begin n_fail++; $display("FAIL w8_overflow_reject: got %0d expected 1", rej_w8); end
        n_checks++; if (val_w8 !== 8'd25) begin n_fail++; $display("FAIL w8_overflow_value: got %0d expected 25", val_w8); end
        n_checks++; if (cnt_w8 !== 2'd2) begin n_fail++; $display("FAIL w8_overflow_count: got %0d expected 2", cnt_w8); end
        digit(4'd5);
        n_checks++; if (val_w8 !== 8'd255) begin n_fail++; $display("FAIL w8_value255: got %0d expected 255", val_w8); end
        n_checks++; if (rej_w8 !== 1'b0) begin n_fail++; $display("FAIL w8_255_noreject: got %0d expected 0", rej_w8); end
        n_checks++; if (cnt_w8 !== 2'd3) begin n_fail++; $display("FAIL w8_count3: got %0d expected 3", cnt_w8); end
        digit(4'd0);
        n_checks++; if (rej_w8 !== 1'b1) begin n_fail++; $display("FAIL w8_maxdigit_reject: got %0d expected 1", rej_w8); end
    endtask

    task automatic test_radix;
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        digit(4'hA);
        n_checks++; if (val_h !== 16'd10) begin n_fail++; $display("FAIL hex_valueA: got %0d expected 10", val_h); end
        digit(4'hF);
        n_checks++; if (val_h !== 16'd175) begin n_fail++; $display("FAIL hex_value175: got %0d expected 175", val_h); end
        n_checks++; if (cnt_h !== 3'd2) begin n_fail++; $display("FAIL hex_count2: got %0d expected 2", cnt_h); end
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        digit(4'd7);
        digit(4'hC);
        n_checks++; if (rej_d !== 1'b1) begin n_fail++; $display("FAIL dec_digitC_reject: got %0d expected 1", rej_d); end
        n_checks++; if (val_d !== 16'd7) begin n_fail++; $display("FAIL dec_digitC_value: got %0d expected 7", val_d); end
        n_checks++; if (cnt_d !== 3'd1) begin n_fail++; $display("FAIL dec_digitC_count: got %0d expected 1", cnt_d); end
    endtask

    task automatic test_edge_cases;
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        digit(4'd0);
        digit(4'd0);
        n_checks++; if (val_d !== 16'd0) begin n_fail++; $display("FAIL zeros_value: got %0d expected 0", val_d); end
        n_checks++; if (cnt_d !== 3'd2) begin n_fail++; $display("FAIL zeros_count: got %0d expected 2", cnt_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (rej_d !== 1'b1) begin n_fail++; $display("FAIL bs_empty_reject: got %0d expected 1", rej_d); end
        n_checks++; if (cnt_d !== 3'd0) begin n_fail++; $display("FAIL bs_empty_count: got %0d expected 0", cnt_d); end
        digit(4'd9);
        apply(4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (val_d !== 16'd0) begin n_fail++; $display("FAIL clear_digit_value: got %0d expected 0", val_d); end
        n_checks++; if (cnt_d !== 3'd0) begin n_fail++; $display("FAIL clear_digit_count: got %0d expected 0", cnt_d); end
        n_checks++; if (rej_d !== 1'b0) begin n_fail++; $display("FAIL clear_digit_noreject: got %0d expected 0", rej_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rej_d !== 1'b1) begin n_fail++; $display("FAIL enter_empty_reject: got %0d expected 1", rej_d); end
        n_checks++; if (rv_d !== 1'b0) begin n_fail++; $display("FAIL enter_empty_valid: got %0d expected 0", rv_d); end
    endtask

    task automatic test_handshake_enter;
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        digit(4'd9);
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (rv_d !== 1'b1) begin n_fail++; $display("FAIL hs_commit_valid: got %0d expected 1", rv_d); end
        n_checks++; if (res_d !== 16'd9) begin n_fail++; $display("FAIL hs_commit_result: got %0d expected 9", res_d); end
        digit(4'd3);
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (rv_d !== 1'b0) begin n_fail++; $display("FAIL hs_transfer_valid: got %0d expected 0", rv_d); end
        n_checks++; if (rej_d !== 1'b1) begin n_fail++; $display("FAIL hs_enter_reject: got %0d expected 1", rej_d); end
        n_checks++; if (val_d !== 16'd3) begin n_fail++; $display("FAIL hs_entry_kept: got %0d expected 3", val_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (res_d !== 16'd3) begin n_fail++; $display("FAIL hs_recommit_result: got %0d expected 3", res_d); end
        n_checks++; if (rv_d !== 1'b1) begin n_fail++; $display("FAIL hs_recommit_valid: got %0d expected 1", rv_d); end
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset;
        apply(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        digit(4'd1);
        digit(4'd2);
        apply(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        digit(4'd4);
        digit(4'd5);
        digit(4'd6);
        n_checks++; if (cnt_d !== 3'd3) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 3", cnt_d); end
        n_checks++; if (rv_d !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %0d expected 1", rv_d); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (val_d !== 16'd0) begin n_fail++; $display("FAIL areset_value: got %0d expected 0", val_d); end
        n_checks++; if (cnt_d !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", cnt_d); end
        n_checks++; if (res_d !== 16'd0) begin n_fail++; $display("FAIL areset_result: got %0d expected 0", res_d); end
        n_checks++; if (rv_d !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %0d expected 0", rv_d); end
        n_checks++; if (rej_d !== 1'b0) begin n_fail++; $display("FAIL areset_reject: got %0d expected 0", rej_d); end
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_pending_entry();
        test_digit_limit();
        test_overflow();
        test_radix();
        test_edge_cases();
        test_handshake_enter();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/digit_entry_buffer.md
# digit_entry_buffer

Parametrised keypad number-entry register that builds a multi-digit value from one-digit-per-strobe keyboard input. It extends the single-register decimal accumulator with a configurable radix, width and digit limit, backspace and clear editing, overflow rejection, and a valid/ready commit port. The block sits between the keyboard decoder and the arithmetic/display logic. Committed operands are handed downstream while a new number is already being typed.

## Interface
Parameters:
- WIDTH, 16, bit width of the entered value and of the committed result
- RADIX, 10, digit base; legal range 2..16
- MAX_DIGITS, 4, maximum number of digits held in one entry; legal range 1..8

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- keyboard_digit  input  4  digit code, sampled when digit_enable=1
- digit_enable  input  1  one-cycle strobe: append keyboard_digit
- backspace  input  1  one-cycle strobe: remove the last digit
- clear  input  1  one-cycle strobe: empty the entry
- enter  input  1  one-cycle strobe: commit the entry to the result port
- value  output  WIDTH  current entry value (registered)
- digit_count  output  CW=$clog2(MAX_DIGITS+1)  digits currently held
- reject  output  1  one-cycle pulse: the previous cycle's request was refused
- result  output  WIDTH  committed value; stable while result_valid=1
- result_valid  output  1  committed value pending
- result_ready  input  1  downstream accepts result when high with result_valid

## Operation
- History stack: MAX_DIGITS entries of WIDTH bits. A digit push stores the pre-push value at index digit_count. Backspace restores the value from index digit_count-1. No division hardware.
- Command priority per cycle: clear > enter > backspace > digit_enable. Lower-priority strobes in the same cycle are dropped silently and do not raise reject.
- Digit accept: requires all of keyboard_digit < RADIX, digit_count < MAX_DIGITS, and value*RADIX + keyboard_digit ≤ 2^WIDTH−1. Compute at WIDTH+5 bits before comparing.
  - On accept: value ← value*RADIX + digit and digit_count+1.
  - On any failure: value and count unchanged, reject pulses.
- Leading zeros count as digits. Entering 0 then 0 gives value 0 and count 2.
- Backspace:
  - count>0: restore from stack, count−1.
  - count=0: no change, reject pulses.
- Clear: value←0, count←0. Never rejects. Does not touch result or result_valid.
- Result FSM has two states, EMPTY and FULL. result_valid=1 iff state is FULL.
  - EMPTY + enter with count>0: result←value, entry cleared to 0/0, go to FULL.
  - EMPTY + enter with count=0: ignored, reject pulses.
  - FULL + enter: refused, entry untouched, reject pulses.
  - FULL with result_ready=1 at a clock edge: go to EMPTY.
- Entry editing (digits, backspace, clear) is allowed in both states, so typing continues while a result is pending.
- Reset mid-entry or mid-handshake discards everything. No result is delivered.

## Timing
- Reset values: value=0, digit_count=0, reject=0, result=0, result_valid=0, state EMPTY, stack contents don't-care.
- All outputs are registered. A strobe sampled at edge N is reflected in value, digit_count, result_valid and reject after edge N. Latency is 1 cycle.
- reject is high for exactly one cycle per refused request.
- Handshake:
  - Transfer occurs at an edge where result_valid=1 and result_ready=1. result_valid falls after that edge.
  - result_ready while result_valid=0 has no effect.
  - Edge with state FULL, result_ready=1 and enter=1 with count>0: the transfer completes and enter is refused (reject pulses). The new commit is accepted no earlier than the next cycle.
- Back-to-back strobes on consecutive cycles are all honoured. No idle cycle is required.

## Test plan
- Defaults; digits 4, 6 -> value 4 then 46; enter with result_ready=0 -> result=46, result_valid=1, value=0, count=0.
- Defaults; digits 3, 2, 7, 5, then 8 -> value 3275, count 4; fifth digit rejected, reject pulses once; backspace ×2 -> 32, then 3.
- WIDTH=8, MAX_DIGITS=3; digits 2, 5, 6 -> 25 accepted, 256 rejected with value staying 25; digit 5 -> 255 accepted.
- RADIX=16; digits 0xA, 0xF -> value 175; RADIX=10 with digit 0xC -> reject, value unchanged.
- Result pending (46, ready=0); type 1, 2 -> value 12; enter -> reject; raise ready one cycle -> result_valid falls; enter -> result=12.
- Assert reset asynchronously mid-clock while count=3 and result_valid=1 -> all outputs 0 immediately. Edge cases: backspace at count 0 -> reject; clear+digit_enable same cycle -> value 0, no reject.
